// File: rtl/rgbi_palette_pipe.sv
// RGBI colour-code to OW-bit RGB palette pipeline with loadable LUT, sync/blank delay and pixel CE.
// Optional LUT readback port is built when RGBI_PALETTE_READBACK_EN is defined.
module rgbi_palette_pipe #(
  parameter int CW         = 4,
  parameter int IW         = 4,
  parameter int OW         = 8,
  parameter int DIV        = 8,
  parameter bit SWAP_R     = 1'b1,
  parameter bit SWAP_G     = 1'b0,
  parameter bit SWAP_B     = 1'b1,
  parameter bit BLANK_ZERO = 1'b1
) (
  input  logic             clk_video,
  input  logic             reset_n,
  input  logic [CW-1:0]    r_in,
  input  logic [CW-1:0]    g_in,
  input  logic [CW-1:0]    b_in,
  input  logic [IW-1:0]    i_in,
  input  logic             hblank_in,
  input  logic             vblank_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic [CW+IW-1:0] dn_addr,
  input  logic [OW-1:0]    dn_data,
  input  logic             dn_wr,
`ifdef RGBI_PALETTE_READBACK_EN
  input  logic             dn_rd,
  output logic [OW-1:0]    dn_rdata,
`endif
  output logic [OW-1:0]    r_out,
  output logic [OW-1:0]    g_out,
  output logic [OW-1:0]    b_out,
  output logic             hblank_out,
  output logic             vblank_out,
  output logic             hs_out,
  output logic             vs_out,
  output logic             ce_pix,
  output logic             lut_loaded
);

  localparam int AW    = CW + IW;
  localparam int PW    = CW + IW;
  localparam int DEPTH = 1 << AW;
  localparam int CNTW  = (DIV > 1) ? $clog2(DIV) : 1;

  function automatic logic [CW-1:0] swap_fix(input logic [CW-1:0] c);
    logic [CW-1:0] s;
    s[0] = c[0];
    for (int k = 1; k < CW; k++) s[k] = c[CW-k];
    return s;
  endfunction

  // Top OW bits of {product, zeros}: a left shift when OW is wide, truncation otherwise.
  function automatic logic [OW-1:0] default_curve(input logic [CW-1:0] c, input logic [IW-1:0] i);
    logic [PW-1:0]    p;
    logic [PW+OW-1:0] ext;
    p   = PW'(c) * PW'(i);
    ext = {p, {OW{1'b0}}};
    return ext[PW+OW-1 -: OW];
  endfunction

  function automatic logic [OW-1:0] pix_out(input logic [CW-1:0] c, input logic [IW-1:0] i,
                                            input logic [OW-1:0] q, input logic blank,
                                            input logic loaded);
    if (BLANK_ZERO && blank) return '0;
    if (i == '0)             return '0;
    if (!loaded)             return default_curve(c, i);
    return q;
  endfunction

  logic [2:0][CW-1:0] w_code;
  logic [2:0][AW-1:0] w_raddr;
  logic [2:0][OW-1:0] w_lut_p1;
  logic               w_blank_p1;

  logic [2:0][CW-1:0] r_code_p1;
  logic [IW-1:0]      r_int_p1;
  logic [3:0]         r_tim_p1;
  logic [2:0][OW-1:0] r_pix_p2;
  logic [3:0]         r_tim_p2;
  logic [CNTW-1:0]    r_cnt;
  logic               r_ce;
  logic               r_loaded;

  always_comb begin
    w_code[0] = SWAP_R ? swap_fix(r_in) : r_in;
    w_code[1] = SWAP_G ? swap_fix(g_in) : g_in;
    w_code[2] = SWAP_B ? swap_fix(b_in) : b_in;
    for (int k = 0; k < 3; k++) w_raddr[k] = {w_code[k], i_in};
  end

  // One LUT copy per channel so all three reads happen in the same cycle.
  for (genvar k = 0; k < 3; k++) begin : g_lut
    logic [OW-1:0] r_mem [DEPTH];
    logic [OW-1:0] r_q_p1;
    always_ff @(posedge clk_video) begin
      if (dn_wr) r_mem[dn_addr] <= dn_data;
      r_q_p1 <= r_mem[w_raddr[k]];
    end
    assign w_lut_p1[k] = r_q_p1;
  end

  assign w_blank_p1 = r_tim_p1[3] | r_tim_p1[2];

  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      r_code_p1 <= '0;
      r_int_p1  <= '0;
      r_tim_p1  <= '0;
      r_pix_p2  <= '0;
      r_tim_p2  <= '0;
      r_cnt     <= '0;
      r_ce      <= 1'b0;
      r_loaded  <= 1'b0;
    end else begin
      // Stage 1: swapped codes, intensity and timing alongside the LUT reads
      r_code_p1 <= w_code;
      r_int_p1  <= i_in;
      r_tim_p1  <= {hblank_in, vblank_in, hs_in, vs_in};
      // Stage 2: output select
      for (int k = 0; k < 3; k++)
        r_pix_p2[k] <= pix_out(r_code_p1[k], r_int_p1, w_lut_p1[k], w_blank_p1, r_loaded);
      r_tim_p2  <= r_tim_p1;
      r_ce      <= (r_cnt == '0);
      r_cnt     <= (r_cnt == CNTW'(DIV - 1)) ? '0 : r_cnt + 1'b1;
      if (dn_wr && (dn_addr == {AW{1'b1}})) r_loaded <= 1'b1;
    end
  end

`ifdef RGBI_PALETTE_READBACK_EN
  logic [OW-1:0] r_rb_mem [DEPTH];
  logic [OW-1:0] r_rdata;

  always_ff @(posedge clk_video) begin
    if (dn_wr) r_rb_mem[dn_addr] <= dn_data;
  end

  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n)   r_rdata <= '0;
    else if (dn_rd) r_rdata <= r_rb_mem[dn_addr];
  end

  assign dn_rdata = r_rdata;
`endif

  assign r_out      = r_pix_p2[0];
  assign g_out      = r_pix_p2[1];
  assign b_out      = r_pix_p2[2];
  assign hblank_out = r_tim_p2[3];
  assign vblank_out = r_tim_p2[2];
  assign hs_out     = r_tim_p2[1];
  assign vs_out     = r_tim_p2[0];
  assign ce_pix     = r_ce;
  assign lut_loaded = r_loaded;

endmodule
